// File: rtl/encode_instr_serializer_pkg.sv
// encode_instr_serializer_pkg: shared states, size codes, descriptor type and helpers
package encode_instr_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ESC   = 3'd1,
        OPC   = 3'd2,
        MODRM = 3'd3,
        SIB   = 3'd4,
        DISP  = 3'd5,
        IMM   = 3'd6
    } state_e;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_1    = 2'd1;
    localparam logic [1:0] SZ_2    = 2'd2;
    localparam logic [1:0] SZ_4    = 2'd3;

    typedef struct packed {
        logic        is_2byte;
        logic [7:0]  opc;
        logic        has_modrm;
        logic [7:0]  modrm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [1:0]  disp_size;
        logic [31:0] disp;
        logic [1:0]  imm_size;
        logic [31:0] imm;
    } desc_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        return code == SZ_4 ? 3'd4 : code == SZ_2 ? 3'd2 : code == SZ_1 ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [3:0] instr_length(input desc_t d);
        return 4'(d.is_2byte) + 4'd1 + 4'(d.has_modrm) + 4'(d.has_modrm & d.has_sib)
             + 4'(size_bytes(d.disp_size)) + 4'(size_bytes(d.imm_size));
    endfunction

    // First present field strictly after s; SIB only counts when ModRM is present.
    function automatic state_e next_field(input desc_t d, input state_e s);
        logic [6:0] pres;
        state_e     n;
        pres = {d.imm_size != SZ_NONE, d.disp_size != SZ_NONE, d.has_modrm & d.has_sib,
                d.has_modrm, 1'b1, d.is_2byte, 1'b0};
        n = IDLE;
        for (int i = 6; i > 0; i--)
            if (i > int'(s) && pres[i]) n = state_e'(3'(i));
        return n;
    endfunction

endpackage

// File: rtl/encode_le_field_mux.sv
// encode_le_field_mux: picks little-endian byte cnt of a 32-bit field and flags its final byte
module encode_le_field_mux
    import encode_instr_serializer_pkg::*;
(
    input  logic [31:0] field,
    input  logic [1:0]  size,
    input  logic [1:0]  cnt,
    output logic [7:0]  sel_byte,
    output logic        is_last
);

    assign sel_byte = field[{cnt, 3'b000} +: 8];
    assign is_last  = {1'b0, cnt} == size_bytes(size) - 3'd1;

endmodule

// File: rtl/encode_instr_serializer.sv
// encode_instr_serializer: emits the encoded bytes of one decoded x86 descriptor on a byte stream
module encode_instr_serializer
    import encode_instr_serializer_pkg::*;
#(
    parameter logic [7:0] ESC_BYTE = 8'h0F,
    parameter int          MAX_LEN  = 12,
    localparam int         LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          is_2byte,
    input  logic [7:0]    opc_byte,
    input  logic          has_modrm,
    input  logic [7:0]    modrm,
    input  logic          has_sib,
    input  logic [7:0]    sib,
    input  logic [1:0]    disp_size,
    input  logic [31:0]   disp,
    input  logic [1:0]    imm_size,
    input  logic [31:0]   imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_byte,
    output logic          out_last,
    output logic [LW-1:0] instr_len
);

    state_e        state_q, state_d, nxt;
    desc_t         desc_q, desc_d, in_desc;
    logic [1:0]    cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    disp_byte, imm_byte;
    logic          disp_last, imm_last, field_done;

    assign in_desc = '{is_2byte: is_2byte, opc: opc_byte, has_modrm: has_modrm, modrm: modrm,
                       has_sib: has_sib, sib: sib, disp_size: disp_size, disp: disp,
                       imm_size: imm_size, imm: imm};

    encode_le_field_mux u_disp (
        .field    (desc_q.disp),
        .size     (desc_q.disp_size),
        .cnt      (cnt_q),
        .sel_byte (disp_byte),
        .is_last  (disp_last)
    );

    encode_le_field_mux u_imm (
        .field    (desc_q.imm),
        .size     (desc_q.imm_size),
        .cnt      (cnt_q),
        .sel_byte (imm_byte),
        .is_last  (imm_last)
    );

    assign nxt        = next_field(desc_q, state_q);
    assign field_done = state_q == DISP ? disp_last : state_q == IMM ? imm_last : 1'b1;
    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q != IDLE;
    assign out_last   = out_valid && field_done && nxt == IDLE;
    assign instr_len  = len_q;
    assign out_byte   = state_q == ESC   ? ESC_BYTE     :
                        state_q == OPC   ? desc_q.opc   :
                        state_q == MODRM ? desc_q.modrm :
                        state_q == SIB   ? desc_q.sib   :
                        state_q == DISP  ? disp_byte    :
                        state_q == IMM   ? imm_byte     : 8'h00;

    // Accept a descriptor in IDLE, otherwise step byte/field on each stream handshake.
    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                desc_d  = in_desc;
                len_d   = LW'(instr_length(in_desc));
                state_d = next_field(in_desc, IDLE);
                cnt_d   = 2'd0;
            end
        end else if (out_ready) begin
            state_d = field_done ? nxt : state_q;
            cnt_d   = field_done ? 2'd0 : cnt_q + 2'd1;
        end
    end

    // State, latched descriptor, byte counter and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            desc_q  <= '0;
            cnt_q   <= 2'd0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: doc/encode_instr_serializer.md
Name: encode_instr_serializer

Overview:
- Inverse of the opcode-phase decode path: takes one decoded x86 instruction descriptor and emits its encoded bytes, one per cycle, on a valid/ready byte stream.
- Field order: 0x0F escape, opcode, ModRM, SIB, displacement, immediate.
- Drives the witness/trace generator and decode round-trip benches, which feed its stream back through the decoder to rebuild the unescaped instruction window.

Parameters:
- ESC_BYTE, 8'h0F, escape byte emitted first when is_2byte=1.
- MAX_LEN, 12, maximum encoded length in bytes; sizes instr_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  high only in IDLE; transfer when in_valid & in_ready
- is_2byte  in  1  prefix opcode with ESC_BYTE
- opc_byte  in  8  opcode byte; register-embedded bits already merged
- has_modrm  in  1  emit ModRM
- modrm  in  8  ModRM byte
- has_sib  in  1  emit SIB; ignored unless has_modrm=1
- sib  in  8  SIB byte
- disp_size  in  2  0=none, 1=1B, 2=2B, 3=4B
- disp  in  32  displacement, emitted little-endian
- imm_size  in  2  0=none, 1=1B, 2=2B, 3=4B
- imm  in  32  immediate, emitted little-endian
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer accepts byte
- out_byte  out  8  current encoded byte
- out_last  out  1  final byte of the instruction
- instr_len  out  4  total encoded byte count; valid while out_last=1

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately:
  - state=IDLE, in_ready=1, out_valid=0, out_byte=0, out_last=0, instr_len=0.
  - All latched fields cleared.
  - Reset mid-instruction abandons the instruction. No partial byte is replayed after reset.
- Acceptance:
  - On in_valid & in_ready, register all descriptor fields.
  - in_ready drops the next cycle.
  - First byte is presented with out_valid=1 on cycle N+1.
- States: IDLE -> ESC -> OPC -> MODRM -> SIB -> DISP -> IMM -> IDLE.
  - Absent fields are skipped: ESC if !is_2byte; MODRM if !has_modrm; SIB if !(has_modrm & has_sib); DISP if disp_size=0; IMM if imm_size=0.
- Byte counter:
  - DISP and IMM each use a counter running 0..(1,2,4)-1 and select byte[k] = field[8k+7:8k].
  - Counter resets on entry to each field.
- Stream handshake:
  - A byte advances only on out_valid & out_ready.
  - While out_ready=0, out_byte, out_last and the state hold stable. No byte is ever dropped or duplicated.
- Back-to-back operation:
  - After the last byte handshakes, state returns to IDLE and in_ready=1 in that same next cycle.
  - Zero-bubble chaining is not required. Exactly one idle cycle between instructions is mandated.
- Length:
  - instr_len = is_2byte + 1 + has_modrm + (has_modrm&has_sib) + dsz + isz, where dsz/isz map to 0/1/2/4.
  - Computed at acceptance in 4 bits; max 12.
- out_last is asserted with the final byte only. For a 1-byte opcode with no fields, the opcode byte carries out_last.
- in_valid while busy is ignored; the descriptor must be held by the producer.

Decomposition:
- Shared package (alongside defines.v):
  - State encoding localparams: IDLE, ESC, OPC, MODRM, SIB, DISP, IMM (3 bits).
  - Size-code constants: SZ_NONE, SZ_1, SZ_2, SZ_4.
  - Function size_bytes(code) returning 0/1/2/4.
- One natural sub-module: encode_le_field_mux.
  - Selects byte k of a 32-bit field given a counter.
  - Signals the last byte given the size code.
  - Instantiated for disp and imm.

Test Plan:
- NOP: opc 0x90, all fields absent -> single byte 0x90, out_last=1, instr_len=1, in_ready=1 next cycle.
- ADD r/m32,imm32: opc 0x81, modrm 0x05, disp_size=3 disp 0x12345678, imm_size=3 imm 0xDEADBEEF -> 81 05 78 56 34 12 EF BE AD DE; out_last on 0xDE; instr_len=10.
- 2-byte IMUL: is_2byte, opc 0xAF, modrm 0xC1 -> 0F AF C1; instr_len=3.
- SIB and ignore rule:
  - modrm 0x44, sib 0x24, disp8 0x08 -> 44 24 08.
  - has_sib=1 with has_modrm=0 -> SIB suppressed.
- Backpressure: out_ready low 3 cycles during disp byte 1 -> out_byte holds 0x56, no state change; stream intact after release.
- Reset mid-stream: rst_n low during imm byte 2 -> out_valid=0 immediately; after release in_ready=1 and the next descriptor encodes from its first byte.
